// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if
// Groups the request/response handshake of the sequencer and the command
// and data lines that go to and come from the downstream Multiplier.
//
//   slave  : the sequencer side (accepts requests, drives the Multiplier)
//   master : the environment side (requester plus the attached Multiplier)
//
// Signals
//   req_valid / req_ready : request handshake, accepted when both are high
//   funct                 : request code (MULTU, MFHI, MFLO)
//   srcA / srcB           : MULTU operands
//   mul_dataA / mul_dataB : operands held for the Multiplier
//   mul_Signal            : Multiplier command (idle, MULTU, OUT)
//   mul_dataOut           : 64-bit product from the Multiplier
//   rd_data / rd_valid    : HI/LO read result and its one-cycle qualifier
//   busy                  : an operation is in progress
//   err                   : one-cycle pulse on an accepted unknown funct
interface mul_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  funct;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] mul_dataA;
    logic [31:0] mul_dataB;
    logic [5:0]  mul_Signal;
    logic [63:0] mul_dataOut;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        err;

    modport slave (
        input  req_valid, funct, srcA, srcB, mul_dataOut,
        output req_ready, mul_dataA, mul_dataB, mul_Signal,
               rd_data, rd_valid, busy, err
    );

    modport master (
        output req_valid, funct, srcA, srcB, mul_dataOut,
        input  req_ready, mul_dataA, mul_dataB, mul_Signal,
               rd_data, rd_valid, busy, err
    );
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer
// Sequences an external iterative Multiplier for MULTU requests and serves
// MFHI/MFLO reads of the HI/LO product registers.
//
// A MULTU latches its operands, holds the MULTU command for MUL_CYCLES
// cycles, issues OUT for one cycle, then captures the 64-bit product into
// HI/LO during a final CAPTURE cycle. Reads complete in IDLE with a one
// cycle registered response, so they can be issued back to back.
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-high reset
//   bus   : mul_sequencer_if.slave (request handshake, read port, Multiplier)
module mul_sequencer #(
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    mul_sequencer_if.slave  bus
);

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    localparam logic [5:0] CMD_IDLE  = 6'b000000;
    localparam logic [5:0] CMD_MULTU = 6'b011001;
    localparam logic [5:0] CMD_OUT   = 6'b111111;

    // Counter only needs to hold MUL_CYCLES-1.
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL     = 2'd1,
        OUT     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] mul_a_reg;
    logic [31:0] mul_b_reg;
    logic [31:0] rd_data_reg;
    logic        rd_valid_reg;
    logic        err_reg;

    logic        ready;
    logic        accept;
    logic [5:0]  mul_cmd;

    assign ready  = (state_reg == IDLE);
    assign accept = bus.req_valid && ready;

    // State register and cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Next-state logic and Multiplier command decode
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        mul_cmd    = CMD_IDLE;
        case (state_reg)
            IDLE: begin
                if (accept && (bus.funct == FUNCT_MULTU)) begin
                    state_next = MUL;
                    count_next = CNT_LOAD;
                end
            end
            MUL: begin
                mul_cmd = CMD_MULTU;
                // Counter reaching zero marks the last of MUL_CYCLES cycles.
                if (count_reg == '0) begin
                    state_next = OUT;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            OUT: begin
                mul_cmd    = CMD_OUT;
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand latches, HI/LO, and the registered read/err outputs.
    // Requests are only accepted in IDLE, so a request can never collide
    // with the HI/LO write in CAPTURE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            mul_a_reg    <= '0;
            mul_b_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
            if (accept) begin
                case (bus.funct)
                    FUNCT_MULTU: begin
                        mul_a_reg <= bus.srcA;
                        mul_b_reg <= bus.srcB;
                    end
                    FUNCT_MFHI: begin
                        rd_data_reg  <= hi_reg;
                        rd_valid_reg <= 1'b1;
                    end
                    FUNCT_MFLO: begin
                        rd_data_reg  <= lo_reg;
                        rd_valid_reg <= 1'b1;
                    end
                    default: begin
                        err_reg <= 1'b1;
                    end
                endcase
            end
            if (state_reg == CAPTURE) begin
                hi_reg <= bus.mul_dataOut[63:32];
                lo_reg <= bus.mul_dataOut[31:0];
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.busy       = ~ready;
    assign bus.mul_Signal = mul_cmd;
    assign bus.mul_dataA  = mul_a_reg;
    assign bus.mul_dataB  = mul_b_reg;
    assign bus.rd_data    = rd_data_reg;
    assign bus.rd_valid   = rd_valid_reg;
    assign bus.err        = err_reg;

endmodule
